quadrant_color_detector: RTL and testbench
==========================================

Name: quadrant_color_detector

Overview:
Per-frame colour detector feeding the minigame FSM's detect_LT/RT/LB/RB inputs. It counts target-colour pixels in each screen quadrant of the active RGB565 pixel stream and thresholds the counts at each frame end. Detection flags are latched and held stable for a full frame, so the consumer can sample them on any vsync rising edge.

Parameters:
H_ACT, 640, active pixels per line; left/right split at H_ACT/2
V_ACT, 480, active lines per frame; top/bottom split at V_ACT/2
R_MIN, 5'd20, minimum R5 for a colour match
G_MAX, 6'd24, maximum G6 for a colour match
B_MAX, 5'd12, maximum B5 for a colour match
PIX_THRESH, 2000, quadrant match count at or above which detect asserts
PIX_THRESH_LO, 1500, release threshold; used only with HYSTERESIS_EN
CNT_W, 17, counter width; must hold (H_ACT/2)*(V_ACT/2)

Ports:
clk  in  1  pixel/system clock
reset  in  1  asynchronous, active-high
vsync  in  1  frame sync, active high; rising edge = frame end
de  in  1  pixel valid (active video)
x  in  10  pixel column of current pixel
y  in  10  pixel row of current pixel
rgb  in  16  RGB565 pixel {R5,G6,B5}
detect_LT  out  1  top-left quadrant detected
detect_RT  out  1  top-right quadrant detected
detect_LB  out  1  bottom-left quadrant detected
detect_RB  out  1  bottom-right quadrant detected
frame_tick  out  1  one-cycle pulse when detect_* are updated
frame_valid  out  1  high once the first complete frame has been evaluated

Behaviour:
- Reset: all detect_* = 0, frame_tick = 0, frame_valid = 0, all four counters = 0, state = SYNC_WAIT, vs_d = 1.
- vs_d = 1 at reset is required: vsync held high through reset release must not produce a false edge.
- Frame-end event: fe = vsync & ~vs_d, evaluated in the same cycle. vs_d is registered every cycle.
- Pixel match, combinational: de=1, x<H_ACT, y<V_ACT, R5>=R_MIN, G6<=G_MAX, B5<=B_MAX.
- Quadrant selection: left = x<H_ACT/2; top = y<V_ACT/2.
- Pixels with de=0 or out-of-range x/y are ignored.
- Counters increment on the clock edge of a matching pixel and saturate at all-ones; no wrap.
- States:
  - SYNC_WAIT: counters accumulate, but the counts belong to a partial frame. On fe: clear counters, no detect update, no frame_tick, go to ACCUM.
  - ACCUM: accumulate. On fe:
    - detect_q <= (cnt_q >= PIX_THRESH) for each quadrant.
    - frame_tick = 1 for exactly the next cycle.
    - frame_valid <= 1.
    - counters reset.
    - Stay in ACCUM.
- Latency: detect_* and frame_tick change on the clock edge at which fe is high; both are visible the cycle after the vsync rise.
- Simultaneous matching pixel and fe:
  - The comparison uses the counts before that pixel.
  - The pixel's quadrant counter reloads to 1; the other counters reload to 0.
- vsync high for many cycles: only one fe. Counters keep accumulating any de pixels; there are normally none.
- Reset mid-frame: everything returns to reset values, and the next frame end is discarded via SYNC_WAIT.
- detect_* are constant between frame_tick pulses.

Optional Feature:
HYSTERESIS_EN
- Defined: at fe, a quadrant whose detect is 0 sets when count >= PIX_THRESH. A quadrant whose detect is 1 clears only when count < PIX_THRESH_LO; otherwise it holds.
- Undefined: single threshold as in Behaviour, and PIX_THRESH_LO is unused.

Test Plan:
Use H_ACT=16, V_ACT=8, PIX_THRESH=10, PIX_THRESH_LO=5 unless stated.
1. Reset with vsync=1, then release -> no frame_tick; frame_valid=0; detect_*=0; state SYNC_WAIT.
2. Partial frame, then fe; then a full frame with 12 matching TL pixels and 3 matching BR pixels, then fe -> first fe gives no tick; second gives frame_tick=1 for 1 cycle, detect_LT=1, others 0, frame_valid=1.
3. Frame with exactly 9 and exactly 10 matching pixels in RT -> detect_RT=0 then 1. Pixels with R5=R_MIN-1, or x=16/y=8 with de=1, are not counted.
4. Matching LB pixel on the fe cycle after 10 LB pixels -> detect_LB=1 from the pre-pixel count of 10. The next frame starts with LB count=1, so 9 more matches give detect_LB=1.
5. Reset asserted mid-frame with counts 8 -> outputs 0 immediately; the next fe is discarded; counts restart from 0.
6. HYSTERESIS_EN with RT counts 12, 7, 4 over three frames -> detect_RT 1, 1, 0. Without the macro -> 1, 0, 0.

Source files
------------

// File: rtl/quadrant_color_detector.sv
// Per-frame quadrant colour detector: counts target-colour RGB565 pixels per screen
// quadrant and thresholds them on each vsync rise. Optional macro: HYSTERESIS_EN.
module quadrant_color_detector #(
  parameter int          H_ACT         = 640,
  parameter int          V_ACT         = 480,
  parameter logic [4:0]  R_MIN         = 5'd20,
  parameter logic [5:0]  G_MAX         = 6'd24,
  parameter logic [4:0]  B_MAX         = 5'd12,
  parameter int          PIX_THRESH    = 2000,
  parameter int          PIX_THRESH_LO = 1500,
  parameter int          CNT_W         = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vsync,
  input  logic        de,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic [15:0] rgb,
  output logic        detect_LT,
  output logic        detect_RT,
  output logic        detect_LB,
  output logic        detect_RB,
  output logic        frame_tick,
  output logic        frame_valid
);

  localparam logic [9:0]       H_ACT_C  = 10'(H_ACT);
  localparam logic [9:0]       V_ACT_C  = 10'(V_ACT);
  localparam logic [9:0]       H_HALF_C = 10'(H_ACT / 2);
  localparam logic [9:0]       V_HALF_C = 10'(V_ACT / 2);
  localparam logic [CNT_W-1:0] SET_C    = CNT_W'(PIX_THRESH);
`ifdef HYSTERESIS_EN
  localparam logic [CNT_W-1:0] CLR_C    = CNT_W'(PIX_THRESH_LO);
`endif

  typedef enum logic [0:0] {
    SYNC_WAIT = 1'b0,
    ACCUM     = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             vs_q;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [3:0]       det_q, det_d;      // index 0..3 = LT, RT, LB, RB
  logic             tick_q, tick_d;
  logic             valid_q, valid_d;

  logic             fe_s;
  logic             pix_match_s;
  logic [1:0]       quad_s;
  logic [4:0]       r5_s;
  logic [5:0]       g6_s;
  logic [4:0]       b5_s;

  // Pixel classification and frame-end edge detection
  always_comb begin
    r5_s        = rgb[15:11];
    g6_s        = rgb[10:5];
    b5_s        = rgb[4:0];
    fe_s        = vsync & ~vs_q;
    quad_s      = {(y >= V_HALF_C), (x >= H_HALF_C)};
    pix_match_s = de && (x < H_ACT_C) && (y < V_ACT_C) &&
                  (r5_s >= R_MIN) && (g6_s <= G_MAX) && (b5_s <= B_MAX);
  end

  // Quadrant counters: a pixel on the frame-end cycle seeds the next frame's count
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (fe_s) begin
        cnt_d[i] = {{(CNT_W-1){1'b0}}, (pix_match_s && (quad_s == 2'(i)))};
      end else if (pix_match_s && (quad_s == 2'(i)) && !(&cnt_q[i])) begin
        cnt_d[i] = cnt_q[i] + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // Frame FSM: the first frame end after reset only synchronises
  always_comb begin
    state_d = state_q;
    det_d   = det_q;
    tick_d  = 1'b0;
    valid_d = valid_q;
    case (state_q)
      SYNC_WAIT: begin
        if (fe_s) begin
          state_d = ACCUM;
        end else begin
          state_d = SYNC_WAIT;
        end
      end
      ACCUM: begin
        state_d = ACCUM;
        if (fe_s) begin
          tick_d  = 1'b1;
          valid_d = 1'b1;
          for (int i = 0; i < 4; i++) begin
`ifdef HYSTERESIS_EN
            det_d[i] = det_q[i] ? (cnt_q[i] >= CLR_C) : (cnt_q[i] >= SET_C);
`else
            det_d[i] = (cnt_q[i] >= SET_C);
`endif
          end
        end else begin
          det_d = det_q;
        end
      end
      default: begin
        state_d = SYNC_WAIT;
      end
    endcase
  end

  // State, counter and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SYNC_WAIT;
      vs_q    <= 1'b1;
      det_q   <= 4'b0000;
      tick_q  <= 1'b0;
      valid_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= {CNT_W{1'b0}};
      end
    end else begin
      state_q <= state_d;
      vs_q    <= vsync;
      det_q   <= det_d;
      tick_q  <= tick_d;
      valid_q <= valid_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign detect_LT   = det_q[0];
  assign detect_RT   = det_q[1];
  assign detect_LB   = det_q[2];
  assign detect_RB   = det_q[3];
  assign frame_tick  = tick_q;
  assign frame_valid = valid_q;

endmodule

// File: tb/tb_quadrant_color_detector.sv
// Self-checking bench for quadrant_color_detector: directed frames plus random
// pixels against a frame-level reference model; honours HYSTERESIS_EN.
module tb_quadrant_color_detector;

  localparam int H  = 16;
  localparam int V  = 8;
  localparam int TH = 10;
  localparam int LO = 5;
  localparam int CNT_MAX = (1 << 17) - 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        vsync;
  logic        de;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [15:0] rgb;
  logic        detect_LT, detect_RT, detect_LB, detect_RB;
  logic        frame_tick, frame_valid;

  int checks = 0;
  int passes = 0;
  int ticks_seen = 0;

  // reference model state
  int       m_cnt [4];
  bit [3:0] m_det;
  bit       m_valid, m_tick, m_sync, m_vs_prev;

  quadrant_color_detector #(
    .H_ACT(H), .V_ACT(V), .PIX_THRESH(TH), .PIX_THRESH_LO(LO)
  ) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .de(de), .x(x), .y(y), .rgb(rgb),
    .detect_LT(detect_LT), .detect_RT(detect_RT), .detect_LB(detect_LB),
    .detect_RB(detect_RB), .frame_tick(frame_tick), .frame_valid(frame_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic bit is_match(input logic de_i, input int xi, input int yi, input int c);
    int r, g, b;
    r = c / 2048;
    g = (c / 32) % 64;
    b = c % 32;
    return de_i && xi < H && yi < V && r >= 20 && g <= 24 && b <= 12;
  endfunction

  function automatic int quad_of(input int xi, input int yi);
    return (yi >= V / 2 ? 2 : 0) + (xi >= H / 2 ? 1 : 0);
  endfunction

  function automatic bit next_det(input bit cur, input int cnt);
`ifdef HYSTERESIS_EN
    if (cur) return cnt >= LO;
    else return cnt >= TH;
`else
    return cnt >= TH;
`endif
  endfunction

  function automatic logic [15:0] match_rgb();
    return {5'($urandom_range(31, 20)), 6'($urandom_range(24, 0)), 5'($urandom_range(12, 0))};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_det = 4'b0000;
    m_valid = 1'b0;
    m_tick = 1'b0;
    m_sync = 1'b1;
    m_vs_prev = 1'b1;
  endtask

  // one clock: drive at edge+1, update model at the edge, compare at edge+1
  task automatic step(input logic vs_i, input logic de_i, input int xi, input int yi, input logic [15:0] c);
    bit fe, hit;
    int q;
    vsync = vs_i; de = de_i; x = 10'(xi); y = 10'(yi); rgb = c;
    @(posedge clk);
    fe = vs_i && !m_vs_prev;
    m_vs_prev = vs_i;
    hit = is_match(de_i, xi, yi, int'(c));
    q = quad_of(xi, yi);
    m_tick = 1'b0;
    if (fe) begin
      if (!m_sync) begin
        for (int i = 0; i < 4; i++) m_det[i] = next_det(m_det[i], m_cnt[i]);
        m_tick = 1'b1;
        m_valid = 1'b1;
      end
      m_sync = 1'b0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end
    if (hit) m_cnt[q] = (m_cnt[q] < CNT_MAX) ? m_cnt[q] + 1 : CNT_MAX;
    #1;
    if (frame_tick === 1'b1) ticks_seen++;
    chk("frame_tick", 32'(frame_tick), 32'(m_tick));
    chk("detect", 32'({detect_RB, detect_LB, detect_RT, detect_LT}), 32'(m_det));
    chk("frame_valid", 32'(frame_valid), 32'(m_valid));
  endtask

  task automatic pix_in_q(input int q, input int n);
    for (int k = 0; k < n; k++)
      step(1'b0, 1'b1, (q % 2) * (H / 2) + $urandom_range(H / 2 - 1, 0),
           (q / 2) * (V / 2) + $urandom_range(V / 2 - 1, 0), match_rgb());
  endtask

  task automatic frame_end();
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 0, 0, 16'h0000);
    for (int k = 0; k < 2; k++) step(1'b0, 1'b0, 0, 0, 16'h0000);
  endtask

  task automatic random_frame(input int n);
    for (int k = 0; k < n; k++)
      step(1'b0, ($urandom_range(3, 0) != 0), $urandom_range(H + 2, 0), $urandom_range(V + 2, 0),
           ($urandom_range(1, 0) != 0) ? match_rgb() : 16'($urandom()));
  endtask

  initial begin
    int t0;
    reset = 1'b1; vsync = 1'b1; de = 1'b0; x = 10'd0; y = 10'd0; rgb = 16'h0000;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tick", 32'(frame_tick), 32'd0);
    chk("rst_valid", 32'(frame_valid), 32'd0);
    chk("rst_detect", 32'({detect_RB, detect_LB, detect_RT, detect_LT}), 32'd0);
    reset = 1'b0;

    // vsync still high after release: no false frame end
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 0, 0, 16'h0000);
    chk("rel_ticks", 32'(ticks_seen), 32'd0);

    // partial frame discarded, then a full frame: 12 TL, 3 BR
    step(1'b0, 1'b0, 0, 0, 16'h0000);
    pix_in_q(0, 4);
    frame_end();
    chk("sync_ticks", 32'(ticks_seen), 32'd0);
    chk("sync_valid", 32'(frame_valid), 32'd0);
    pix_in_q(0, 12);
    pix_in_q(3, 3);
    frame_end();
    chk("f1_ticks", 32'(ticks_seen), 32'd1);
    chk("f1_detect", 32'({detect_RB, detect_LB, detect_RT, detect_LT}), 32'b0001);
    chk("f1_valid", 32'(frame_valid), 32'd1);

    // RT threshold boundary, plus pixels that must not count
    pix_in_q(1, 9);
    step(1'b0, 1'b1, 12, 1, {5'd19, 6'd0, 5'd0});
    step(1'b0, 1'b1, 16, 1, {5'd31, 6'd0, 5'd0});
    step(1'b0, 1'b1, 12, 8, {5'd31, 6'd0, 5'd0});
    frame_end();
    chk("rt9_detect", 32'(detect_RT), 32'd0);
    pix_in_q(1, 10);
    frame_end();
    chk("rt10_detect", 32'(detect_RT), 32'd1);

    // matching LB pixel on the frame-end cycle
    pix_in_q(2, 10);
    step(1'b1, 1'b1, 3, 6, match_rgb());
    step(1'b1, 1'b0, 0, 0, 16'h0000);
    step(1'b0, 1'b0, 0, 0, 16'h0000);
    chk("lb_fe_detect", 32'({detect_RB, detect_LB, detect_RT, detect_LT}), 32'b0100);
    pix_in_q(2, 9);
    frame_end();
    chk("lb_carry_detect", 32'(detect_LB), 32'd1);

    // asynchronous reset mid-frame
    pix_in_q(0, 8);
    t0 = ticks_seen;
    reset = 1'b1;
    #1;
    chk("mid_rst_detect", 32'({detect_RB, detect_LB, detect_RT, detect_LT}), 32'd0);
    chk("mid_rst_valid", 32'(frame_valid), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    pix_in_q(0, 12);
    frame_end();
    chk("post_rst_ticks", 32'(ticks_seen - t0), 32'd0);
    chk("post_rst_valid", 32'(frame_valid), 32'd0);
    pix_in_q(0, 10);
    frame_end();
    chk("post_rst_lt", 32'(detect_LT), 32'd1);

    // RT counts 12, 7, 4 over three frames
    pix_in_q(1, 12);
    frame_end();
    chk("hy_12", 32'(detect_RT), 32'd1);
    pix_in_q(1, 7);
    frame_end();
`ifdef HYSTERESIS_EN
    chk("hy_7", 32'(detect_RT), 32'd1);
`else
    chk("hy_7", 32'(detect_RT), 32'd0);
`endif
    pix_in_q(1, 4);
    frame_end();
    chk("hy_4", 32'(detect_RT), 32'd0);

    // random frames against the model
    for (int f = 0; f < 8; f++) begin
      random_frame($urandom_range(120, 30));
      frame_end();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
